// File: rtl/dma_ch_engine.sv
// ============================================================================
// Module   : dma_ch_engine
// Purpose  : Per-channel DMA transfer engine. Requests service from the
//            channel arbiter and runs one burst per grant. Phase t0 reads
//            source memory into an internal FIFO; phase t1 writes FIFO
//            contents to destination memory.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            ch_en, target       - channel enable, transfer phase select
//            src_addr, dst_addr,
//            xfer_len            - configuration, sampled on ch_en rising
//            periph_req          - peripheral service request (level)
//            req / ack / en      - arbiter request, acknowledge, grant
//            req_done, t0_done,
//            fifo_empty/full     - status back to the arbiter
//            bus_*               - single-outstanding-beat memory bus
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_ch_engine #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int FIFO_AW = 3,
  parameter int BURST   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ch_en,
  input  logic          target,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [15:0]   xfer_len,
  input  logic          periph_req,
  output logic          req,
  input  logic          ack,
  input  logic          en,
  output logic          req_done,
  output logic          t0_done,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ready
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BCW   = $clog2(BURST + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  localparam logic [AW-1:0]    STEP      = AW'(DW / 8);
  localparam logic [BCW-1:0]   LAST_BEAT = BCW'(BURST - 1);
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] ALMOST    = (FIFO_AW + 1)'(DEPTH - 1);
  localparam logic [FIFO_AW:0] ONE_WORD  = (FIFO_AW + 1)'(1);

  logic [2:0]         state_q,   state_d;
  logic [AW-1:0]      src_q,     src_d;
  logic [AW-1:0]      dst_q,     dst_d;
  logic [15:0]        rd_left_q, rd_left_d;
  logic [15:0]        wr_left_q, wr_left_d;
  logic [BCW-1:0]     bcnt_q,    bcnt_d;
  logic [FIFO_AW-1:0] wptr_q,    wptr_d;
  logic [FIFO_AW-1:0] rptr_q,    rptr_d;
  logic [FIFO_AW:0]   cnt_q,     cnt_d;
  logic               empty_q,   empty_d;
  logic               full_q,    full_d;
  logic               req_q,     req_d;
  logic               armed_q,   armed_d;
  logic               ch_en_q;

  logic [DW-1:0]      mem [DEPTH];

  // A beat is only presented when it can actually complete; an RD/WR state
  // without work falls through to DONE without ever raising bus_req.
  logic w_rd_go, w_wr_go, w_push, w_pop, w_rise;

  assign w_rd_go = ch_en && (state_q == S_RD) && (rd_left_q != 16'd0) && !full_q;
  assign w_wr_go = ch_en && (state_q == S_WR) && (wr_left_q != 16'd0) && !empty_q;
  assign w_push  = w_rd_go && bus_ready;
  assign w_pop   = w_wr_go && bus_ready;
  assign w_rise  = ch_en && !ch_en_q;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rd_left_d = rd_left_q;
    wr_left_d = wr_left_q;
    bcnt_d    = bcnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    armed_d   = armed_q;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          bcnt_d  = '0;
          state_d = target ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (!w_rd_go) begin
          state_d = S_DONE;
        end else if (bus_ready) begin
          src_d     = src_q + STEP;
          rd_left_d = rd_left_q - 16'd1;
          bcnt_d    = bcnt_q + 1'b1;
          // Values before this beat: last of burst, last word, or FIFO full after push.
          if (bcnt_q == LAST_BEAT || rd_left_q == 16'd1 || cnt_q == ALMOST)
            state_d = S_DONE;
        end
      end
      S_WR: begin
        if (!w_wr_go) begin
          state_d = S_DONE;
        end else if (bus_ready) begin
          dst_d     = dst_q + STEP;
          wr_left_d = wr_left_q - 16'd1;
          bcnt_d    = bcnt_q + 1'b1;
          if (bcnt_q == LAST_BEAT || wr_left_q == 16'd1 || cnt_q == ONE_WORD)
            state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_WAIT;
      S_WAIT:  if (!en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (w_push) begin
      wptr_d = wptr_q + 1'b1;
      cnt_d  = cnt_q + 1'b1;
    end
    if (w_pop) begin
      rptr_d = rptr_q + 1'b1;
      cnt_d  = cnt_q - 1'b1;
    end

    if (w_rise) begin
      src_d     = src_addr;
      dst_d     = dst_addr;
      rd_left_d = xfer_len;
      wr_left_d = xfer_len;
      wptr_d    = '0;
      rptr_d    = '0;
      cnt_d     = '0;
    end

    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == FULL_CNT);

    if (!ch_en) state_d = S_IDLE;

    // After an ack the request re-arms only once periph_req has been low.
    if (!periph_req) armed_d = 1'b1;
    else if (ack)    armed_d = 1'b0;

    if (!ch_en)                                  req_d = 1'b0;
    else if (ack)                                req_d = 1'b0;
    else if (!req_q && periph_req && armed_q)    req_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rd_left_q <= '0;
      wr_left_q <= '0;
      bcnt_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      req_q     <= 1'b0;
      armed_q   <= 1'b1;
      ch_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rd_left_q <= rd_left_d;
      wr_left_q <= wr_left_d;
      bcnt_q    <= bcnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      req_q     <= req_d;
      armed_q   <= armed_d;
      ch_en_q   <= ch_en;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem[wptr_q] <= bus_rdata;
  end

  assign req        = req_q;
  assign req_done   = (state_q == S_DONE);
  assign t0_done    = ch_en && (rd_left_q == 16'd0);
  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign bus_req    = w_rd_go || w_wr_go;
  assign bus_we     = w_wr_go;
  assign bus_addr   = w_wr_go ? dst_q : (w_rd_go ? src_q : '0);
  assign bus_wdata  = w_wr_go ? mem[rptr_q] : '0;

endmodule

`default_nettype wire

// File: tb/tb_dma_ch_engine.sv
// ============================================================================
// Module   : tb_dma_ch_engine
// Purpose  : Self-checking bench for dma_ch_engine. A queue-based model of
//            the FIFO plus running address/length counters predicts the
//            beats, addresses and data of every grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_ch_engine;

  localparam int AW = 32, DW = 32, FIFO_AW = 3, BURST = 4, DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ch_en = 1'b0, target = 1'b0, periph_req = 1'b0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0;
  logic [15:0]   xfer_len = '0;
  logic          ack = 1'b0, en = 1'b0;
  logic          req, req_done, t0_done, fifo_empty, fifo_full;
  logic          bus_req, bus_we, bus_ready = 1'b0;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata = '0;

  dma_ch_engine #(.AW(AW), .DW(DW), .FIFO_AW(FIFO_AW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .target(target),
    .src_addr(src_addr), .dst_addr(dst_addr), .xfer_len(xfer_len),
    .periph_req(periph_req), .req(req), .ack(ack), .en(en),
    .req_done(req_done), .t0_done(t0_done), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: FIFO contents and the channel's running pointers/counts.
  logic [DW-1:0] m_q[$];
  logic [AW-1:0] m_src, m_dst;
  int            m_rd, m_wr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  task automatic configure(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [15:0] len);
    en = 1'b0;
    ch_en = 1'b0;
    tick();
    src_addr = s;
    dst_addr = d;
    xfer_len = len;
    ch_en = 1'b1;
    tick();
    m_src = s;
    m_dst = d;
    m_rd  = len;
    m_wr  = len;
    m_q.delete();
    chk("cfg_fifo_empty", fifo_empty, 1);
    chk("cfg_t0_done", t0_done, (len == 0));
  endtask

  // One arbiter grant: serve bus beats with up to maxws wait states each,
  // compare every accepted beat with the model, then hold en past req_done.
  task automatic grant(input logic tgt, input int maxws);
    int n, beats, ws, dones;
    logic holding;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wd, rd;
    logic h_we;
    n = tgt ? min3(BURST, m_q.size(), m_wr) : min3(BURST, m_rd, DEPTH - m_q.size());
    beats = 0; ws = 0; dones = 0; holding = 1'b0;
    h_addr = '0; h_wd = '0; h_we = 1'b0;
    target = tgt;
    en = 1'b1;
    bus_ready = 1'b0;
    tick();
    target = 1'($urandom);   // mid-burst change must be ignored
    for (int c = 0; c < 100 && dones == 0; c++) begin
      if (req_done) begin
        dones++;
      end else if (bus_req) begin
        if (holding) begin
          chk("hold_addr", bus_addr, h_addr);
          chk("hold_we", bus_we, h_we);
          chk("hold_wdata", bus_wdata, h_wd);
        end else begin
          chk("beat_addr", bus_addr, tgt ? m_dst : m_src);
          chk("beat_we", bus_we, tgt);
          if (tgt) chk("beat_wdata", bus_wdata, m_q[0]);
          h_addr = bus_addr; h_we = bus_we; h_wd = bus_wdata;
          ws = $urandom_range(maxws, 0);
        end
        if (ws == 0) begin
          bus_ready = 1'b1;
          if (!tgt) begin
            rd = $urandom;
            bus_rdata = rd;
            m_q.push_back(rd);
            m_src += 4;
            m_rd--;
          end else begin
            void'(m_q.pop_front());
            m_dst += 4;
            m_wr--;
          end
          beats++;
          holding = 1'b0;
        end else begin
          bus_ready = 1'b0;
          bus_rdata = $urandom;
          ws--;
          holding = 1'b1;
        end
      end else begin
        bus_ready = 1'b0;
      end
      tick();
    end
    bus_ready = 1'b0;
    chk("req_done_seen", dones, 1);
    chk("burst_beats", beats, n);
    for (int k = 0; k < 3; k++) begin
      chk("post_done_pulse", req_done, 0);
      chk("post_done_bus", bus_req, 0);
      tick();
    end
    en = 1'b0;
    tick();
    chk("fifo_empty", fifo_empty, (m_q.size() == 0));
    chk("fifo_full", fifo_full, (m_q.size() == DEPTH));
    chk("t0_done", t0_done, (m_rd == 0));
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_req", req, 0);
    chk("rst_req_done", req_done, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_fifo_empty", fifo_empty, 1);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_t0_done", t0_done, 0);
    rst = 1'b0;
    tick();

    // t0 bursts of 4 then 2 words, then t1 drain in two grants
    configure(32'h1000, 32'h2000, 16'd6);
    grant(1'b0, 0);
    grant(1'b0, 0);
    grant(1'b1, 0);
    grant(1'b1, 0);
    grant(1'b1, 0);   // empty FIFO: zero-beat grant

    // Request handshake
    periph_req = 1'b1;
    tick();
    chk("req_set", req, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("req_clr", req, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("req_no_rearm", req, 0);
    end
    periph_req = 1'b0;
    tick();
    chk("req_low", req, 0);
    periph_req = 1'b1;
    tick();
    chk("req_rearm", req, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    periph_req = 1'b0;
    chk("req_clr2", req, 0);

    // FIFO full with no drain, then a further t0 grant sees a full FIFO
    configure({$urandom_range(255, 0), 8'h00}, 32'h4000, 16'd20);
    grant(1'b0, 3);
    grant(1'b0, 0);
    grant(1'b0, 2);
    chk("full_after_fill", fifo_full, 1);
    grant(1'b0, 0);

    // Randomized mixed traffic with wait states
    for (int i = 0; i < 14; i++) grant(1'($urandom_range(1, 0)), 5);

    // Zero-length transfer
    configure(32'h5000, 32'h6000, 16'd0);
    grant(1'b0, 0);
    grant(1'b1, 0);

    // Abort mid-RD by dropping ch_en
    configure(32'h7000, 32'h8000, 16'd10);
    target = 1'b0;
    en = 1'b1;
    tick();
    tick();
    chk("abort_busreq_before", bus_req, 1);
    chk("abort_addr", bus_addr, 32'h7000);
    ch_en = 1'b0;
    #1;
    chk("abort_busreq_drop", bus_req, 0);
    tick();
    chk("abort_idle_bus", bus_req, 0);
    chk("abort_no_done", req_done, 0);
    en = 1'b0;
    tick();
    configure(32'h9000, 32'hA000, 16'd5);
    grant(1'b0, 1);

    // Asynchronous reset mid-burst
    periph_req = 1'b1;
    target = 1'b0;
    en = 1'b1;
    tick();
    chk("mid_req", req, 1);
    chk("mid_bus_req", bus_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_bus_req", bus_req, 0);
    chk("arst_req", req, 0);
    chk("arst_req_done", req_done, 0);
    chk("arst_fifo_empty", fifo_empty, 1);
    chk("arst_fifo_full", fifo_full, 0);
    en = 1'b0;
    periph_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
